mem_access_unit: RTL
====================

# mem_access_unit

Initiator for the data port (port B) of the dual-port BRAM main memory. Turns byte/half/word load and store requests from the core's memory stage into word-aligned BRAM commands: it computes lane enables and shifts store data, absorbs the one-cycle read latency, and extracts and sign-/zero-extends load data. Misaligned or out-of-range accesses are rejected with a fault and never reach memory.

## Interface
Parameters:
- MEM_SIZE, 8192: memory size in bytes; must match the attached memory. AW = $clog2(MEM_SIZE).

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  request was rejected
- mem_addr  out  AW  to memory addr_b
- mem_wdata  out  32  to memory data_i_b
- mem_rdata  in  32  from memory data_o_b, valid the cycle after the address is presented
- mem_data_en  out  4  to memory data_en_b
- mem_write_en  out  1  to memory write_en_b

## Operation
- FSM states: IDLE, LOAD_WAIT, RESP.
- In IDLE, a request is accepted in cycle T when req_valid && req_ready.
- Fault check at acceptance; a fault occurs on any of:
  - req_size == 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - req_addr >= MEM_SIZE
- Faulted request: no memory command issued. Next state RESP with resp_fault = 1 and resp_rdata = 0.
- Memory command is driven combinationally during the accept cycle T only. mem_addr = req_addr[AW-1:0]. Outside T: mem_write_en = 0, mem_data_en = 0, mem_addr and mem_wdata = 0.
- Lane rules, with off = addr[1:0]:
  - byte: mem_data_en = 0001 << off; wdata[7:0] replicated to all four lanes.
  - half: mem_data_en = 0011 << off; wdata[15:0] replicated to both halves.
  - word: mem_data_en = 1111; mem_wdata = wdata.
- Store: mem_write_en = 1 in T. Next state RESP with resp_rdata = 0.
- Load: mem_write_en = 0; mem_data_en is driven with the lane pattern anyway (the memory ignores it on reads). Next state LOAD_WAIT; off, size and unsigned are registered.
- LOAD_WAIT (T+1): extract from mem_rdata using the registered off and size.
  - byte: lane mem_rdata[8*off+7 : 8*off].
  - half: mem_rdata[16*off[1]+15 : 16*off[1]].
  - Extend to 32 bits per the registered unsigned flag.
  - Register the result into resp_rdata. Next state RESP.
- RESP: resp_valid = 1; resp_rdata and resp_fault are held stable until resp_ready. On resp_valid && resp_ready, go to IDLE and clear the response outputs.

## Timing
- Reset values: state IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_fault = 0; all mem_* outputs 0.
- Store and fault latency: resp_valid at T+1.
- Load latency: resp_valid at T+2.
- resp_ready may be held high: minimum issue spacing is then 2 cycles for stores and faults, 3 for loads. No request is accepted in the same cycle a response is consumed; req_ready rises the cycle after.
- req_* inputs are sampled only in the accept cycle. Changes at any other time are ignored.
- Reset mid-operation:
  - rst_n low immediately forces mem_write_en and mem_data_en to 0, including during an accept cycle.
  - An in-flight load or response is discarded; no resp_valid follows.
- Address wrap: none. Addresses at or above MEM_SIZE fault; no modulo addressing.

## Structure
- Package mem_pkg:
  - access_size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - lsu_state_t enum (IDLE, LOAD_WAIT, RESP).
  - Lane-enable constants BE_BYTE = 4'b0001, BE_HALF = 4'b0011, BE_WORD = 4'b1111.
- Sub-module load_extract: combinational; inputs rdata, off, size, unsigned; output is the 32-bit extended value. It is instantiated once, in the LOAD_WAIT path.

## Test plan
- Store byte 0xA5 to addr 0x0006 -> mem_data_en = 0100, mem_wdata = 0xA5A5A5A5 and mem_write_en = 1 in T; resp_valid at T+1 with resp_fault = 0.
- Word 0x80FF1234 preloaded at 0x0004; load signed half at 0x0006 -> resp_rdata = 0xFFFF80FF at T+2. Same load unsigned -> 0x000080FF. Signed byte at 0x0005 -> 0x00000012.
- Load word at 0x0002, and store at addr 8192 -> resp_fault = 1 at T+1, resp_rdata = 0, mem_write_en never asserted.
- Hold resp_ready low 5 cycles after a load -> resp_valid and resp_rdata stable throughout, req_ready = 0; resp_ready high -> IDLE next cycle.
- Pull rst_n low during LOAD_WAIT -> outputs immediately at reset values, no resp_valid after release; the next request behaves normally.
- Back-to-back store then load of the same word with resp_ready tied high -> load returns the stored value; accepts occur at T and T+2.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the data-port memory access
//               unit. Holds the access-size encoding, the access-unit FSM
//               states and the base lane-enable patterns.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Encoding matches the req_size field; 2'b11 is not a legal access size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RESP      = 2'b10
    } lsu_state_t;

    // Lane patterns for an access at byte offset 0; shifted by the offset.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational load-data aligner. Selects the addressed byte
//               or halfword lane of a memory word and sign- or zero-extends
//               it to 32 bits. Word accesses pass through unchanged.
// Ports       : rdata       in  32  word read from memory
//               off         in  2   byte offset of the access in the word
//               size        in  2   access size (access_size_t)
//               is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//               data        out 32  extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0]  rdata,
    input  logic [1:0]   off,
    input  access_size_t size,
    input  logic         is_unsigned,
    output logic [31:0]  data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // Halfwords are 2-byte aligned, so only off[1] picks the half.
        w_byte = rdata[{off, 3'b000} +: 8];
        w_half = rdata[{off[1], 4'b0000} +: 16];

        case (size)
            SIZE_BYTE: data = is_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SIZE_HALF: data = is_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default:   data = rdata;
        endcase
    end

endmodule : load_extract
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Data-port initiator for the dual-port BRAM main memory.
//               Converts byte/half/word loads and stores into word-aligned
//               memory commands with lane enables, absorbs the one-cycle read
//               latency and returns extended load data. Misaligned, illegal
//               size and out-of-range requests fault without touching memory.
// Ports       : clk, rst_n                         clock, async active-low reset
//               req_valid/req_ready                 request handshake
//               req_we, req_size, req_unsigned      request attributes
//               req_addr, req_wdata                 byte address, store data
//               resp_valid/resp_ready               response handshake
//               resp_rdata, resp_fault              response payload
//               mem_addr, mem_wdata, mem_data_en,
//               mem_write_en, mem_rdata             memory port B
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int MEM_SIZE = 8192,
    localparam int AW       = $clog2(MEM_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_fault,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [3:0]    mem_data_en,
    output logic          mem_write_en
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    lsu_state_t   r_state;
    lsu_state_t   w_next_state;
    access_size_t w_size;
    logic [1:0]   w_off;
    logic         w_fault;
    logic         w_accept;
    logic         w_cmd;
    logic [3:0]   w_lanes;
    logic [31:0]  w_lane_wdata;
    logic [31:0]  w_ext;

    logic [1:0]   r_off;
    access_size_t r_size;
    logic         r_unsigned;
    logic [31:0]  r_rdata;
    logic         r_fault;

    assign w_size = access_size_t'(req_size);
    assign w_off  = req_addr[1:0];

    // No address wrap: anything at or beyond the memory size is rejected.
    assign w_fault = (req_size == 2'b11)
                  || ((w_size == SIZE_HALF) && req_addr[0])
                  || ((w_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_addr >= MEM_LIMIT);

    // Lane enables and lane-replicated store data for the addressed bytes.
    always_comb begin
        w_lanes      = '0;
        w_lane_wdata = '0;
        case (w_size)
            SIZE_BYTE: begin
                w_lanes      = BE_BYTE << w_off;
                w_lane_wdata = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                w_lanes      = BE_HALF << w_off;
                w_lane_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_lanes      = BE_WORD;
                w_lane_wdata = req_wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (w_fault || req_we) ? RESP : LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                w_next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Memory command exists only in the accept cycle of a legal request.
    // rst_n is folded in so an asserted reset kills a command immediately,
    // without waiting for the state register to be observed.
    assign w_cmd        = rst_n && w_accept && !w_fault;
    assign mem_write_en = w_cmd && req_we;
    assign mem_data_en  = w_cmd ? w_lanes : 4'b0000;
    assign mem_addr     = w_cmd ? req_addr[AW-1:0] : '0;
    assign mem_wdata    = w_cmd ? w_lane_wdata : 32'd0;

    // ---------------------------------------------------------- datapath
    load_extract u_load_extract (
        .rdata       (mem_rdata),
        .off         (r_off),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .data        (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off      <= 2'b00;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_rdata    <= 32'd0;
            r_fault    <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_fault;
            r_rdata <= 32'd0;
            if (!req_we) begin
                r_off      <= w_off;
                r_size     <= w_size;
                r_unsigned <= req_unsigned;
            end
        end else if (r_state == LOAD_WAIT) begin
            r_rdata <= w_ext;
        end else if (resp_valid && resp_ready) begin
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;

endmodule : mem_access_unit
`default_nettype wire
